// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator for one video mode. It sits in front of the TMDS
//   encoders. A horizontal and a vertical counter walk the raster. A single
//   output register stage turns the current (h, v) position into the pixel
//   position, data-enable and sync outputs, so every output is registered and
//   all outputs describe the same pixel.
//
// Ports
//   I_clk          in   pixel clock
//   I_rst_n        in   asynchronous active-low reset
//   I_enable       in   1 = advance the raster, 0 = freeze the raster
//   O_x, O_y       out  pixel position, one cycle behind the counters
//   O_de           out  active-video indicator
//   O_hsync        out  horizontal sync at the HS_POL active level
//   O_vsync        out  vertical sync at the VS_POL active level
//   O_ctrl_data    out  {O_vsync, O_hsync}, for the blue-channel encoder
//   O_line_start   out  one-cycle pulse when O_x == 0
//   O_frame_start  out  one-cycle pulse when O_x == 0 and O_y == 0
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 12
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_enable,
    output logic [CNT_W-1:0] O_x,
    output logic [CNT_W-1:0] O_y,
    output logic             O_de,
    output logic             O_hsync,
    output logic             O_vsync,
    output logic [1:0]       O_ctrl_data,
    output logic             O_line_start,
    output logic             O_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CNT_W < 1 || CNT_W > 30 ||
        H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_bad_params
        $error("video_timing_gen: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    logic de_cur;
    logic hs_act;
    logic vs_act;
    logic hs_lvl;
    logic vs_lvl;

    // Raster counters; v_cnt only moves on the h_cnt wrap.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (I_enable) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Decode of the current position. vsync depends on v_cnt alone,
    // so it only ever changes at a line boundary.
    always_comb begin
        de_cur = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_act = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
        vs_act = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
        hs_lvl = hs_act ? HS_POL : ~HS_POL;
        vs_lvl = vs_act ? VS_POL : ~VS_POL;
    end

    // Output stage. While frozen everything holds, except the start pulses,
    // which are cleared so that each one lasts exactly one cycle.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_x           <= '0;
            O_y           <= '0;
            O_de          <= 1'b0;
            O_hsync       <= ~HS_POL;
            O_vsync       <= ~VS_POL;
            O_ctrl_data   <= {~VS_POL, ~HS_POL};
            O_line_start  <= 1'b0;
            O_frame_start <= 1'b0;
        end else if (I_enable) begin
            O_x           <= h_cnt;
            O_y           <= v_cnt;
            O_de          <= de_cur;
            O_hsync       <= hs_lvl;
            O_vsync       <= vs_lvl;
            O_ctrl_data   <= {vs_lvl, hs_lvl};
            O_line_start  <= (h_cnt == '0);
            O_frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            O_line_start  <= 1'b0;
            O_frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: default 640x480 mode
    logic        rst_a = 1'b0, en_a = 1'b0;
    logic [11:0] a_x, a_y;
    logic        a_de, a_hs, a_vs, a_ls, a_fs;
    logic [1:0]  a_ctrl;

    // B: medium mode H 16/2/3/3 (24), V 10/2/2/3 (17), active-low syncs
    logic        rst_b = 1'b0, en_b = 1'b0;
    logic [11:0] b_x, b_y;
    logic        b_de, b_hs, b_vs, b_ls, b_fs;
    logic [1:0]  b_ctrl;

    // C: small mode H 4/1/2/1 (8), V 3/1/1/1 (6), active-high syncs
    logic        rst_c = 1'b0, en_c = 1'b0;
    logic [3:0]  c_x, c_y;
    logic        c_de, c_hs, c_vs, c_ls, c_fs;
    logic [1:0]  c_ctrl;

    video_timing_gen dut_a (
        .I_clk(clk), .I_rst_n(rst_a), .I_enable(en_a),
        .O_x(a_x), .O_y(a_y), .O_de(a_de), .O_hsync(a_hs), .O_vsync(a_vs),
        .O_ctrl_data(a_ctrl), .O_line_start(a_ls), .O_frame_start(a_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_b (
        .I_clk(clk), .I_rst_n(rst_b), .I_enable(en_b),
        .O_x(b_x), .O_y(b_y), .O_de(b_de), .O_hsync(b_hs), .O_vsync(b_vs),
        .O_ctrl_data(b_ctrl), .O_line_start(b_ls), .O_frame_start(b_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
    ) dut_c (
        .I_clk(clk), .I_rst_n(rst_c), .I_enable(en_c),
        .O_x(c_x), .O_y(c_y), .O_de(c_de), .O_hsync(c_hs), .O_vsync(c_vs),
        .O_ctrl_data(c_ctrl), .O_line_start(c_ls), .O_frame_start(c_fs)
    );

    typedef struct {
        logic en;
        int   x;
        int   y;
        logic de;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_c(input string tag, input int x, input int y, input logic de,
                         input logic hs, input logic vs, input logic ls, input logic fs);
        chk({tag, "_x"},    int'(c_x), x);
        chk({tag, "_y"},    int'(c_y), y);
        chk({tag, "_de"},   int'(c_de), int'(de));
        chk({tag, "_hs"},   int'(c_hs), int'(hs));
        chk({tag, "_vs"},   int'(c_vs), int'(vs));
        chk({tag, "_ctrl"}, int'(c_ctrl), int'({vs, hs}));
        chk({tag, "_ls"},   int'(c_ls), int'(ls));
        chk({tag, "_fs"},   int'(c_fs), int'(fs));
    endtask

    initial begin
        int mx, my, bad, max_x, max_y, hs_hi, steps;
        int de_cnt, hs_low, hs_first, hs_last, ls_cnt, ls_last, ls_period, fs_cnt, vs_low;
        int fs_first_gap, fs_last, vs_bad;
        logic found;

        //            en  x  y  de hs vs ls fs
        vecs[0]  = '{1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held with a running clock and enable high
        en_a = 1'b1;
        repeat (4) tick();
        chk("rst_a_x", int'(a_x), 0);
        chk("rst_a_y", int'(a_y), 0);
        chk("rst_a_de", int'(a_de), 0);
        chk("rst_a_hs", int'(a_hs), 1);
        chk("rst_a_vs", int'(a_vs), 1);
        chk("rst_a_ctrl", int'(a_ctrl), 3);
        chk("rst_a_ls", int'(a_ls), 0);
        chk("rst_a_fs", int'(a_fs), 0);
        chk_c("rst_c", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Small mode: table of the first cycles, including enable holds
        rst_c = 1'b1;
        for (int i = 0; i < 12; i++) begin
            en_c = vecs[i].en;
            tick();
            chk_c($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].de,
                  vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs);
        end

        // Small mode: two full frames against a reference raster
        en_c = 1'b1;
        mx = 2; my = 1; bad = 0; max_x = 0; max_y = 0; hs_hi = 0;
        for (int c = 0; c < 96; c++) begin
            logic ehs, evs, ede;
            tick();
            ede = (mx < 4) && (my < 3);
            ehs = (mx == 5) || (mx == 6);
            evs = (my == 4);
            if (int'(c_x) != mx || int'(c_y) != my || c_de != ede || c_hs != ehs ||
                c_vs != evs || c_ctrl != {evs, ehs} || c_ls != (mx == 0) ||
                c_fs != (mx == 0 && my == 0))
                bad++;
            if (int'(c_x) > max_x) max_x = int'(c_x);
            if (int'(c_y) > max_y) max_y = int'(c_y);
            if (c_hs) hs_hi++;
            if (mx == 7) begin
                mx = 0;
                my = (my == 5) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        chk("small_sweep_bad", bad, 0);
        chk("small_max_x", max_x, 7);
        chk("small_max_y", max_y, 5);
        chk("small_hs_high_cycles", hs_hi, 24);

        // Small mode: async reset in the middle of line 2
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (c_x == 4'd3 && c_y == 4'd2) found = 1'b1;
        end
        chk("small_find_mid_line2", int'(found), 1);
        #2 rst_c = 1'b0;
        #1;
        chk_c("async_rst", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_c("rst_hold", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_c = 1'b1;
        tick();
        chk_c("restart0", 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_c("restart1", 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_c = 1'b0;

        // Default mode: first two lines
        rst_a = 1'b1;
        de_cnt = 0; hs_low = 0; hs_first = -1; hs_last = -1;
        ls_cnt = 0; ls_last = -1; ls_period = -1; fs_cnt = 0; vs_low = 0;
        for (int c = 0; c < 1600; c++) begin
            tick();
            if (c == 0) begin
                chk("first_x", int'(a_x), 0);
                chk("first_y", int'(a_y), 0);
                chk("first_de", int'(a_de), 1);
                chk("first_fs", int'(a_fs), 1);
                chk("first_ls", int'(a_ls), 1);
            end
            if (c == 1) begin
                chk("second_x", int'(a_x), 1);
                chk("second_fs", int'(a_fs), 0);
            end
            if (c == 800) chk("line1_y", int'(a_y), 1);
            if (a_y == 12'd0) begin
                if (a_de) de_cnt++;
                if (!a_hs) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(a_x);
                    hs_last = int'(a_x);
                end
            end
            if (a_ls) begin
                ls_cnt++;
                if (ls_last >= 0 && ls_period < 0) ls_period = c - ls_last;
                ls_last = c;
            end
            if (a_fs) fs_cnt++;
            if (!a_vs) vs_low++;
        end
        chk("line0_de_cycles", de_cnt, 640);
        chk("line0_hs_low_cycles", hs_low, 96);
        chk("line0_hs_first_x", hs_first, 656);
        chk("line0_hs_last_x", hs_last, 751);
        chk("ls_period", ls_period, 800);
        chk("ls_count", ls_cnt, 2);
        chk("fs_count_2lines", fs_cnt, 1);
        chk("vs_low_top_lines", vs_low, 0);
        rst_a = 1'b0;

        // Medium mode: frame-level properties
        rst_b = 1'b1;
        en_b = 1'b1;
        fs_cnt = 0; fs_last = -1; fs_first_gap = -1; vs_low = 0; vs_bad = 0; de_cnt = 0;
        for (int c = 0; c <= 816; c++) begin
            tick();
            if (b_fs) begin
                fs_cnt++;
                if (fs_last >= 0 && fs_first_gap < 0) fs_first_gap = c - fs_last;
                fs_last = c;
            end
            if (c < 408) begin
                if (!b_vs) vs_low++;
                if (b_de) de_cnt++;
            end
            if (!b_vs && b_y != 12'd12 && b_y != 12'd13) vs_bad++;
        end
        chk("med_fs_period", fs_first_gap, 408);
        chk("med_fs_count", fs_cnt, 3);
        chk("med_vs_low_cycles", vs_low, 48);
        chk("med_vs_bad_lines", vs_bad, 0);
        chk("med_de_cycles", de_cnt, 160);

        // Medium mode: enable held low for 37 cycles at the last active pixel
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            tick();
            if (b_x == 12'd15 && b_y == 12'd9) found = 1'b1;
        end
        chk("med_find_last_active", int'(found), 1);
        en_b = 1'b0;
        bad = 0;
        for (int c = 0; c < 37; c++) begin
            tick();
            if (b_x != 12'd15 || b_y != 12'd9 || b_de != 1'b1 || b_hs != 1'b1 ||
                b_vs != 1'b1 || b_ctrl != 2'b11 || b_ls != 1'b0 || b_fs != 1'b0)
                bad++;
        end
        chk("hold_bad_cycles", bad, 0);
        en_b = 1'b1;
        tick();
        steps = 38;
        chk("resume_x", int'(b_x), 16);
        chk("resume_y", int'(b_y), 9);
        chk("resume_de", int'(b_de), 0);
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            tick();
            steps++;
            if (b_fs) found = 1'b1;
        end
        chk("hold_fs_found", int'(found), 1);
        chk("hold_fs_distance", steps, 177 + 37);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
